// File: rtl/spi_target_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_target_responder
// Purpose  : SPI target (mode 0, MSB first) end of the codec link. All pins
//            are oversampled on Clk. One frame is shifted in per CS-low
//            window and published with a one-cycle RxValid pulse. A word
//            staged through TxData/TxLoad is shifted out on SDO during the
//            same frame.
// Ports    : Clk       system clock
//            Reset_    asynchronous active-low reset
//            SCK/CS/SDI serial inputs from the controller (async to Clk)
//            SDO       serial data to the controller (0 whenever CS is high)
//            FrameBits expected bits per frame, sampled at frame start
//            TxData/TxLoad  next transmit word and its capture strobe
//            TxReady   holding register empty
//            RxData/RxBits/RxErr/RxValid  last-frame results and strobe
//            TxUnder   sticky: a frame started with no fresh word
//            Busy      frame in progress
// Revision : 1.0 - initial release
// ============================================================================
module spi_target_responder #(
    parameter int WIDTH       = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             Reset_,
    input  logic             SCK,
    input  logic             CS,
    input  logic             SDI,
    output logic             SDO,
    input  logic [4:0]       FrameBits,
    input  logic [WIDTH-1:0] TxData,
    input  logic             TxLoad,
    output logic             TxReady,
    output logic [WIDTH-1:0] RxData,
    output logic [4:0]       RxBits,
    output logic             RxValid,
    output logic             RxErr,
    output logic             TxUnder,
    output logic             Busy
);

    localparam logic [4:0] c_WIDTH_5 = 5'(WIDTH);
    localparam logic [4:0] c_CNT_MAX = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers: bit 0 takes the pin, bit SYNC_STAGES-1 is safe.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic                   r_sck_d;
    logic                   r_cs_d;

    always_ff @(posedge Clk or negedge Reset_) begin
        if (!Reset_) begin
            r_sck_sync <= '0;
            r_cs_sync  <= '1;
            r_sdi_sync <= '0;
            r_sck_d    <= 1'b0;
            r_cs_d     <= 1'b1;
        end else begin
            r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], CS};
            r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], SDI};
            r_sck_d    <= r_sck_sync[SYNC_STAGES-1];
            r_cs_d     <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    logic w_sck_s;
    logic w_cs_s;
    logic w_sdi_s;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_cs_fall;
    logic w_cs_rise;

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
    assign w_sdi_s    = r_sdi_sync[SYNC_STAGES-1];
    assign w_sck_rise =  w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s &  r_sck_d;
    assign w_cs_fall  = ~w_cs_s  &  r_cs_d;
    assign w_cs_rise  =  w_cs_s  & ~r_cs_d;

    // ------------------------------------------------------------------
    // Frame engine
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [WIDTH-1:0] r_holding;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_rx;
    logic [4:0]       r_count;
    logic [4:0]       r_frame_bits;
    logic             r_flag;

    // A TxLoad landing on the frame-start cycle supplies that frame's word.
    logic             w_pending;
    logic [WIDTH-1:0] w_word;
    logic [4:0]       w_shamt;
    logic [WIDTH-1:0] w_start_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [WIDTH:0]   w_rx_ext;

    assign w_pending     = TxLoad | ~TxReady;
    assign w_word        = TxLoad ? TxData : r_holding;
    // Left-justify a short word so its MSB is the first bit out.
    assign w_shamt       = c_WIDTH_5 - FrameBits;
    assign w_start_shift = w_word << w_shamt;
    assign w_shift_next  = r_shift << 1;
    assign w_rx_ext      = {r_rx, w_sdi_s};

    always_ff @(posedge Clk or negedge Reset_) begin
        if (!Reset_) begin
            r_state      <= S_IDLE;
            r_holding    <= '0;
            r_shift      <= '0;
            r_rx         <= '0;
            r_count      <= '0;
            r_frame_bits <= '0;
            r_flag       <= 1'b0;
            SDO          <= 1'b0;
            TxReady      <= 1'b1;
            RxData       <= '0;
            RxBits       <= '0;
            RxValid      <= 1'b0;
            RxErr        <= 1'b0;
            TxUnder      <= 1'b0;
            Busy         <= 1'b0;
        end else begin
            RxValid <= 1'b0;

            if (TxLoad) begin
                r_holding <= TxData;
                TxReady   <= 1'b0;
                TxUnder   <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_state      <= S_ACTIVE;
                        Busy         <= 1'b1;
                        r_shift      <= w_start_shift;
                        SDO          <= w_start_shift[WIDTH-1];
                        r_rx         <= '0;
                        r_count      <= '0;
                        r_frame_bits <= FrameBits;
                        // CS falling while SCK is high breaks mode-0 framing.
                        r_flag       <= w_sck_s;
                        // Word consumed; overrides the TxLoad clear above.
                        TxReady      <= 1'b1;
                        if (!w_pending) begin
                            TxUnder <= 1'b1;
                        end
                    end
                end

                S_ACTIVE: begin
                    // CS rise wins over a coincident SCK edge.
                    if (w_cs_rise) begin
                        r_state <= S_DONE;
                        Busy    <= 1'b0;
                    end else if (w_sck_rise) begin
                        r_rx <= w_rx_ext[WIDTH-1:0];
                        if (r_count != c_CNT_MAX) begin
                            r_count <= r_count + 5'd1;
                        end
                    end else if (w_sck_fall) begin
                        r_shift <= w_shift_next;
                        SDO     <= w_shift_next[WIDTH-1];
                    end
                end

                S_DONE: begin
                    RxData  <= r_rx;
                    RxBits  <= r_count;
                    RxErr   <= r_flag | (r_count != r_frame_bits);
                    RxValid <= 1'b1;
                    SDO     <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    Busy    <= 1'b0;
                    SDO     <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
